// File: rtl/tlk2711_pkg.sv
// Shared constants, state encoding and CRC helper
// for the TLK2711B transmit framer.
package tlk2711_pkg;

  localparam logic [15:0] K_IDLE     = 16'hC5BC;
  localparam logic [15:0] K_SOF      = 16'h50FB;
  localparam logic [15:0] K_EOF      = 16'h50FD;
  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE,
    SOF,
    DATA,
    CRC,
    EOF,
    IFG
  } state_e;

  // CRC-16/CCITT, one 16-bit word per call, MSB first
  function automatic logic [15:0] crc16_word(
    input logic [15:0] crc,
    input logic [15:0] data
  );
    logic [15:0] c;
    c = crc;
    for (int i = 15; i >= 0; i--) begin
      if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ CRC16_POLY;
      else                 c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/tlk2711_tx_framer_fifo.sv
// First-word-fall-through synchronous FIFO with
// full/empty flags and fill count.
module sync_fifo_fwft #(
  parameter int W = 17,
  parameter int D = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               wr_en_i,
  input  logic [W-1:0]       wr_data_i,
  input  logic               rd_en_i,
  output logic [W-1:0]       rd_data_o,
  output logic               full_o,
  output logic               empty_o,
  output logic [$clog2(D):0] fill_o
);

  localparam int AW = $clog2(D);

  logic [W-1:0]  mem_q [D];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_wr, do_rd;

  assign full_o    = (cnt_q == (AW+1)'(D));
  assign empty_o   = (cnt_q == '0);
  assign fill_o    = cnt_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  // a pop frees the slot, so a push while full is accepted
  assign do_rd = rd_en_i & ~empty_o;
  assign do_wr = wr_en_i & (~full_o | do_rd);

  always_comb begin
    cnt_d = cnt_q;
    unique case ({do_wr, do_rd})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tlk2711_tx_framer.sv
// TLK2711B transmit framer: buffers payload and emits
// SOF / payload / CRC-16 / EOF / idle gap on txd.
module tlk2711_tx_framer
  import tlk2711_pkg::*;
#(
  parameter int          FIFO_DEPTH   = 32,
  parameter int          START_THRESH = 8,
  parameter int          MIN_IFG      = 2,
  parameter logic [15:0] IDLE_WORD    = K_IDLE,
  parameter logic [15:0] SOF_WORD     = K_SOF,
  parameter logic [15:0] EOF_WORD     = K_EOF
) (
  input  logic        sys_clk,
  input  logic        sys_rstn,
  input  logic        tx_en,
  input  logic [15:0] s_tdata,
  input  logic        s_tvalid,
  input  logic        s_tlast,
  output logic        s_tready,
  output logic [15:0] txd,
  output logic        tkmsb,
  output logic        tklsb,
  output logic        busy,
  output logic [31:0] frame_cnt,
  output logic [15:0] underrun_cnt
);

  localparam int          AW  = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] THR = (AW+1)'(START_THRESH);
  localparam logic [15:0] IFG_LAST = 16'(MIN_IFG - 1);

  state_e      state_q;
  logic [15:0] crc_q, txd_q, ifg_q, urun_q;
  logic        tkmsb_q, tklsb_q, busy_q;
  logic [31:0] fcnt_q;
  logic [AW:0] last_cnt_q, last_cnt_d, fill;
  logic [16:0] rd_data;
  logic        full, empty, wr, rd, start;

  assign s_tready = ~full & sys_rstn;
  assign wr       = s_tvalid & s_tready;
  assign rd       = (state_q == DATA) & ~empty;
  assign start    = tx_en & ((last_cnt_q != '0) | (fill >= THR));

  sync_fifo_fwft #(.W(17), .D(FIFO_DEPTH)) u_fifo (
    .clk_i     (sys_clk),
    .rst_ni    (sys_rstn),
    .wr_en_i   (wr),
    .wr_data_i ({s_tlast, s_tdata}),
    .rd_en_i   (rd),
    .rd_data_o (rd_data),
    .full_o    (full),
    .empty_o   (empty),
    .fill_o    (fill)
  );

  always_comb begin
    last_cnt_d = last_cnt_q;
    unique case ({wr & s_tlast, rd & rd_data[16]})
      2'b10:   last_cnt_d = last_cnt_q + 1'b1;
      2'b01:   last_cnt_d = last_cnt_q - 1'b1;
      default: last_cnt_d = last_cnt_q;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rstn) begin
      state_q    <= IDLE;
      crc_q      <= CRC16_INIT;
      txd_q      <= IDLE_WORD;
      tkmsb_q    <= 1'b0;
      tklsb_q    <= 1'b1;
      busy_q     <= 1'b0;
      fcnt_q     <= '0;
      urun_q     <= '0;
      ifg_q      <= '0;
      last_cnt_q <= '0;
    end else begin
      last_cnt_q <= last_cnt_d;
      tkmsb_q    <= 1'b0;
      unique case (state_q)
        IDLE: begin
          txd_q   <= IDLE_WORD;
          tklsb_q <= 1'b1;
          if (start) state_q <= SOF;
        end
        SOF: begin
          txd_q   <= SOF_WORD;
          tklsb_q <= 1'b1;
          crc_q   <= CRC16_INIT;
          busy_q  <= 1'b1;
          state_q <= DATA;
        end
        DATA: begin
          if (!empty) begin
            txd_q   <= rd_data[15:0];
            tklsb_q <= 1'b0;
            crc_q   <= crc16_word(crc_q, rd_data[15:0]);
            if (rd_data[16]) state_q <= CRC;
          end else begin
            // fill idle; receiver discards K words inside a frame
            txd_q   <= IDLE_WORD;
            tklsb_q <= 1'b1;
            if (urun_q != 16'hFFFF) urun_q <= urun_q + 1'b1;
          end
        end
        CRC: begin
          txd_q   <= crc_q;
          tklsb_q <= 1'b0;
          state_q <= EOF;
        end
        EOF: begin
          txd_q   <= EOF_WORD;
          tklsb_q <= 1'b1;
          fcnt_q  <= fcnt_q + 1'b1;
          busy_q  <= 1'b0;
          ifg_q   <= '0;
          state_q <= IFG;
        end
        IFG: begin
          txd_q   <= IDLE_WORD;
          tklsb_q <= 1'b1;
          ifg_q   <= ifg_q + 1'b1;
          if (ifg_q == IFG_LAST) state_q <= start ? SOF : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign txd          = txd_q;
  assign tkmsb        = tkmsb_q;
  assign tklsb        = tklsb_q;
  assign busy         = busy_q;
  assign frame_cnt    = fcnt_q;
  assign underrun_cnt = urun_q;

endmodule
